// File: rtl/pattern_sequencer.sv
//------------------------------------------------------------------------------
// Module      : pattern_sequencer
// Description : Applies a latched 16-bit pattern, LSB first, to an external
//               Moore FSM and counts the cycles on which its output is high.
//               Optional macro PATSEQ_FSM_RESET_EN adds a one-cycle FSM reset
//               phase before each run.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pattern_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pattern,
    input  logic [3:0]  length,
    input  logic        fsm_out,
    output logic        fsm_in,
    output logic        fsm_reset,
    output logic        busy,
    output logic        done,
    output logic [4:0]  hit_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_FSM = 3'd1,
        S_RUN       = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_shift;
    logic [4:0]  r_len;
    logic [4:0]  r_cnt;
    logic [4:0]  r_hits;

    logic        w_start_ok;
    logic        w_last;
    logic        w_sample;
    logic [4:0]  w_len_eff;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_last     = (r_cnt == (r_len - 5'd1));
    assign w_len_eff  = (length == 4'd0) ? 5'd16 : {1'b0, length};

    // The first RUN edge only applies bit 0; its effect is seen one edge later,
    // so sampling skips that edge and picks up the last bit at DRAIN.
    assign w_sample   = ((r_state == S_RUN) && (r_cnt != 5'd0)) || (r_state == S_DRAIN);

    assign hit_count  = r_hits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        fsm_in       = 1'b0;
        fsm_reset    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef PATSEQ_FSM_RESET_EN
                    w_state_next = S_RESET_FSM;
`else
                    w_state_next = S_RUN;
`endif
                end
            end
            S_RESET_FSM: begin
                busy         = 1'b1;
`ifdef PATSEQ_FSM_RESET_EN
                fsm_reset    = 1'b1;
`endif
                w_state_next = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                fsm_in = r_shift[0];
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= 16'd0;
            r_len   <= 5'd0;
            r_cnt   <= 5'd0;
            r_hits  <= 5'd0;
        end else begin
            if (w_start_ok) begin
                r_shift <= pattern;
                r_len   <= w_len_eff;
                r_cnt   <= 5'd0;
                r_hits  <= 5'd0;
            end else begin
                if (r_state == S_RUN) begin
                    r_shift <= r_shift >> 1;
                    r_cnt   <= r_cnt + 5'd1;
                end
                if (w_sample && fsm_out) begin
                    r_hits <= r_hits + 5'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_pattern_sequencer
// Description : Directed bench driving pattern_sequencer against a 4-state
//               Moore detector model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pattern_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [3:0]  length;
    logic        fsm_out;
    logic        fsm_in;
    logic        fsm_reset;
    logic        busy;
    logic        done;
    logic [4:0]  hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] c_A = 2'd0;
    localparam logic [1:0] c_B = 2'd1;
    localparam logic [1:0] c_C = 2'd2;
    localparam logic [1:0] c_D = 2'd3;

    logic [1:0] r_m_state;
    logic       w_tb_fsm_rst;

`ifdef PATSEQ_FSM_RESET_EN
    localparam int c_PRE = 1;
    assign w_tb_fsm_rst = 1'b0;
`else
    // Without the DUT reset phase the detector is parked in B between runs.
    localparam int c_PRE = 0;
    assign w_tb_fsm_rst = ~busy;
`endif

    pattern_sequencer u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .length    (length),
        .fsm_out   (fsm_out),
        .fsm_in    (fsm_in),
        .fsm_reset (fsm_reset),
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m_state <= c_B;
        end else if (fsm_reset || w_tb_fsm_rst) begin
            r_m_state <= c_B;
        end else begin
            case (r_m_state)
                c_B:     r_m_state <= fsm_in ? c_A : c_D;
                c_A:     r_m_state <= fsm_in ? c_C : c_D;
                c_C:     r_m_state <= fsm_in ? c_B : c_C;
                default: r_m_state <= fsm_in ? c_B : c_A;
            endcase
        end
    end

    assign fsm_out = (r_m_state == c_A);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller sets start/pattern/length; the first tick passes the start edge.
    task automatic run_body(input int L, input logic [15:0] exp_seq,
                            input logic [31:0] exp_st, input logic [4:0] exp_hits,
                            input bit hold, input bit chg, input string tag);
        int          n;
        logic [15:0] seq;
        logic [31:0] st;
        bit          bad_idle;
        seq      = '0;
        st       = '0;
        bad_idle = 1'b0;
        tick();
        n = 1;
        if (!hold) start = 1'b0;
        if (chg) begin
            pattern = 16'h0007;
            length  = 4'd3;
        end
        check({tag, ":busy_start"}, busy, 1);
        check({tag, ":fsm_reset"}, fsm_reset, c_PRE);
        while (!done && n < 40) begin
            if (n >= c_PRE + 1 && n <= c_PRE + L) seq[n - c_PRE - 1] = fsm_in;
            else if (fsm_in !== 1'b0) bad_idle = 1'b1;
            if (n >= c_PRE + 2 && n <= c_PRE + L + 1) st[2 * (n - c_PRE - 2) +: 2] = r_m_state;
            tick();
            n++;
        end
        check({tag, ":latency"}, n - 1, L + 1 + c_PRE);
        check({tag, ":done"}, done, 1);
        check({tag, ":busy_done"}, busy, 0);
        check({tag, ":fsm_in_seq"}, seq, exp_seq);
        check({tag, ":fsm_in_idle"}, {31'd0, bad_idle} | {31'd0, fsm_in}, 0);
        check({tag, ":states"}, st, exp_st);
        check({tag, ":hits"}, hit_count, exp_hits);
        tick();
        check({tag, ":done_width"}, done, 0);
        check({tag, ":busy_after"}, busy, 0);
        check({tag, ":hits_hold"}, hit_count, exp_hits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        reset   = 1'b1;
        start   = 1'b0;
        pattern = 16'h0000;
        length  = 4'd0;
        tick();
        start   = 1'b1;
        tick();
        check("rst:fsm_in", fsm_in, 0);
        check("rst:fsm_reset", fsm_reset, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:hits", hit_count, 0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        pattern = 16'h0001; length = 4'd1; start = 1'b1;
        run_body(1, 16'h0001, 32'h0000_0000, 5'd1, 1'b0, 1'b0, "V1");

        pattern = 16'h0007; length = 4'd3; start = 1'b1;
        run_body(3, 16'h0007, 32'h0000_0018, 5'd1, 1'b0, 1'b0, "V2");

        pattern = 16'h0000; length = 4'd4; start = 1'b1;
        run_body(4, 16'h0000, 32'h0000_0033, 5'd2, 1'b0, 1'b0, "V3");

        pattern = 16'hFFFF; length = 4'd0; start = 1'b1;
        run_body(16, 16'hFFFF, 32'h1861_8618, 5'd6, 1'b0, 1'b0, "V4");

        // Start held high and inputs changed mid-run; the second run must
        // pick up the new values only from IDLE after DONE.
        pattern = 16'h0000; length = 4'd4; start = 1'b1;
        run_body(4, 16'h0000, 32'h0000_0033, 5'd2, 1'b1, 1'b1, "V5a");
        run_body(3, 16'h0007, 32'h0000_0018, 5'd1, 1'b0, 1'b0, "V5b");

        pattern = 16'hFFFF; length = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (c_PRE + 2) tick();
        check("V6:busy_run", busy, 1);
        check("V6:hits_pre", hit_count, 1);
        check("V6:fsm_in_pre", fsm_in, 1);
        reset = 1'b1;
        #1;
        check("V6:fsm_in", fsm_in, 0);
        check("V6:fsm_reset", fsm_reset, 0);
        check("V6:busy", busy, 0);
        check("V6:done", done, 0);
        check("V6:hits", hit_count, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("V6:no_done", {31'd0, saw_done}, 0);

        pattern = 16'h0001; length = 4'd1; start = 1'b1;
        run_body(1, 16'h0001, 32'h0000_0000, 5'd1, 1'b0, 1'b0, "V6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
